// File: rtl/mac_pkg.sv
// Shared MAC-array package: psum widths, column count and the packed-slice index helper.
// Used by the MAC column array and by the psum output collector.
package mac_pkg;

    localparam int BW      = 8;
    localparam int BW_PSUM = 2*BW + 6;
    localparam int COL     = 8;

    // LSB position of column c inside a packed row of w-bit psums.
    function automatic int psum_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column circular psum queue: storage, write/read pointers and occupancy count.
// The parent only asserts pop when every column is non-empty, so pop never underflows.
module ofifo_col
    import mac_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [bw_psum-1:0] din,
    output logic [bw_psum-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [bw_psum-1:0] mem [depth];
    logic [aw-1:0]      wptr;
    logic [aw-1:0]      rptr;
    logic [cw-1:0]      count;
    logic               do_push;

    assign full    = (count == cw'(depth));
    assign empty   = (count == '0);
    // A full column still takes the write when the same edge frees a slot.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + aw'(1);
            if (pop)
                rptr <= rptr + aw'(1);
            if (do_push && !pop)
                count <= count + cw'(1);
            else if (!do_push && pop)
                count <= count - cw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/psum_ofifo.sv
// Psum output collector: per-column queues re-align skewed MAC column writes into full rows.
// Optional build macro OFIFO_RELU_EN zeroes negative psums on the read path only.
module psum_ofifo
    import mac_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic                   o_valid,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    logic [col-1:0]         full_c;
    logic [col-1:0]         empty_c;
    logic [col-1:0]         drop_c;
    logic [col*bw_psum-1:0] head;
    logic                   pop;
    logic                   ovf_q;

    assign o_valid = ~|empty_c;
    assign o_full  = |full_c;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;
    assign o_ovf   = ovf_q;

    for (genvar c = 0; c < col; c++) begin : g_col
        ofifo_col #(
            .bw_psum (bw_psum),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (pop),
            .din   (in[psum_lsb(c, bw_psum) +: bw_psum]),
            .dout  (head[psum_lsb(c, bw_psum) +: bw_psum]),
            .full  (full_c[c]),
            .empty (empty_c[c]),
            .drop  (drop_c[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf_q <= 1'b0;
        else if (|drop_c)
            ovf_q <= 1'b1;
    end

    always_comb begin
        out = head;
`ifdef OFIFO_RELU_EN
        for (int c = 0; c < col; c++) begin
            if (head[psum_lsb(c, bw_psum) + bw_psum - 1])
                out[psum_lsb(c, bw_psum) +: bw_psum] = '0;
        end
`endif
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo against a per-column queue reference model.
module tb_psum_ofifo;
    import mac_pkg::*;

    localparam int NC = 8;
    localparam int W  = 22;
    localparam int D  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   wr;
    logic [NC*W-1:0] in_bus;
    logic            rd;
    logic            o_valid;
    logic [NC*W-1:0] out_bus;
    logic            o_full;
    logic            o_ready;
    logic            o_ovf;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] mq [NC][$];
    bit           m_ovf;

    always #5 clk = ~clk;

    psum_ofifo #(.col(NC), .bw_psum(W), .depth(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .in      (in_bus),
        .rd      (rd),
        .o_valid (o_valid),
        .out     (out_bus),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_ovf   (o_ovf)
    );

    function automatic bit m_valid();
        for (int c = 0; c < NC; c++)
            if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < NC; c++)
            if (mq[c].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef OFIFO_RELU_EN
        if (v[W-1]) return '0;
`endif
        return v;
    endfunction

    function automatic logic [NC*W-1:0] m_out();
        logic [NC*W-1:0] o = '0;
        for (int c = 0; c < NC; c++)
            if (mq[c].size() > 0) o[c*W +: W] = relu(mq[c][0]);
        return o;
    endfunction

    function automatic logic [NC*W-1:0] rand_row();
        logic [NC*W-1:0] r;
        for (int c = 0; c < NC; c++) r[c*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_ovf = 1'b0;
    endtask

    // Apply one clock of stimulus, advance the model, return 1 ns after the edge.
    task automatic step(input logic [NC-1:0] w, input logic [NC*W-1:0] d, input logic r);
        bit pop_row;
        wr = w; in_bus = d; rd = r;
        @(posedge clk);
        pop_row = r && m_valid();
        if (pop_row)
            for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
        for (int c = 0; c < NC; c++) begin
            if (w[c]) begin
                if (mq[c].size() < D) mq[c].push_back(d[c*W +: W]);
                else m_ovf = 1'b1;
            end
        end
        #1;
        wr = '0; rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr = '0; rd = 1'b0; in_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({o_valid, o_full, o_ready, o_ovf} !== 4'b0010) begin
            nerr++;
            $display("FAIL reset_held got=%b exp=0010", {o_valid, o_full, o_ready, o_ovf});
        end
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step('0, rand_row(), 1'b1);
            nvec++;
            if ({o_valid, o_full, o_ready, o_ovf} !== 4'b0010) begin
                nerr++;
                $display("FAIL reset_rd_ignored i=%0d got=%b exp=0010", i, {o_valid, o_full, o_ready, o_ovf});
            end
        end
    endtask

    task automatic test_skewed_fill();
        logic [NC*W-1:0] d;
        for (int c = 0; c < NC; c++) begin
            d = '0;
            d[c*W +: W] = W'(100 + c);
            step(NC'(1) << c, d, 1'b0);
            nvec++;
            if (o_valid !== (c == NC-1)) begin
                nerr++;
                $display("FAIL skew_valid c=%0d got=%b exp=%b", c, o_valid, (c == NC-1));
            end
        end
        for (int c = 0; c < NC; c++) begin
            nvec++;
            if (out_bus[c*W +: W] !== W'(100 + c)) begin
                nerr++;
                $display("FAIL skew_out c=%0d got=%0d exp=%0d", c, out_bus[c*W +: W], 100 + c);
            end
        end
        step('0, '0, 1'b1);
        nvec++;
        if (o_valid !== 1'b0) begin
            nerr++;
            $display("FAIL skew_pop_valid got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_full_ovf();
        logic [NC*W-1:0] rows [D];
        logic [NC*W-1:0] extra;
        for (int r = 0; r < D; r++) begin
            rows[r] = rand_row();
            step('1, rows[r], 1'b0);
        end
        nvec++;
        if ({o_valid, o_full, o_ready, o_ovf} !== 4'b1100) begin
            nerr++;
            $display("FAIL full_status got=%b exp=1100", {o_valid, o_full, o_ready, o_ovf});
        end
        extra = rand_row();
        step(NC'(8), extra, 1'b0);
        nvec++;
        if ({o_full, o_ovf} !== 2'b11) begin
            nerr++;
            $display("FAIL ovf_set got=%b exp=11", {o_full, o_ovf});
        end
        for (int r = 0; r < D; r++) begin
            nvec++;
            if (o_valid !== 1'b1 || out_bus !== m_out() || mq[3][0] !== rows[r][3*W +: W]) begin
                nerr++;
                $display("FAIL full_drain r=%0d valid=%b got=%h exp=%h", r, o_valid, out_bus, m_out());
            end
            step('0, '0, 1'b1);
        end
        nvec++;
        if ({o_valid, o_full, o_ovf} !== 3'b001) begin
            nerr++;
            $display("FAIL full_after_drain got=%b exp=001", {o_valid, o_full, o_ovf});
        end
    endtask

    task automatic test_wrap_simul();
        for (int r = 0; r < D-1; r++) step('1, rand_row(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step('1, rand_row(), 1'b1);
            nvec++;
            if (o_valid !== 1'b1 || o_full !== 1'b0 || out_bus !== m_out() || mq[0].size() != D-1) begin
                nerr++;
                $display("FAIL wrap i=%0d valid=%b full=%b got=%h exp=%h", i, o_valid, o_full, out_bus, m_out());
            end
        end
        for (int r = 0; r < D-1; r++) begin
            nvec++;
            if (o_valid !== 1'b1 || out_bus !== m_out()) begin
                nerr++;
                $display("FAIL wrap_drain r=%0d valid=%b got=%h exp=%h", r, o_valid, out_bus, m_out());
            end
            step('0, '0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] w;
        logic          r;
        for (int i = 0; i < 400; i++) begin
            w = NC'($urandom);
            r = 1'($urandom_range(0, 1));
            step(w, rand_row(), r);
            nvec++;
            if ({o_valid, o_full, o_ready, o_ovf} !== {m_valid(), m_full(), ~m_full(), m_ovf}) begin
                nerr++;
                $display("FAIL rand_status i=%0d got=%b exp=%b", i, {o_valid, o_full, o_ready, o_ovf},
                         {m_valid(), m_full(), ~m_full(), m_ovf});
            end
            if (m_valid()) begin
                nvec++;
                if (out_bus !== m_out()) begin
                    nerr++;
                    $display("FAIL rand_out i=%0d got=%h exp=%h", i, out_bus, m_out());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NC*W-1:0] d;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
        for (int r = 0; r < 5; r++) step('1, rand_row(), 1'b0);
        nvec++;
        if (o_valid !== 1'b1) begin
            nerr++;
            $display("FAIL mid_prefill got=%b exp=1", o_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        nvec++;
        if ({o_valid, o_full, o_ready, o_ovf} !== 4'b0010) begin
            nerr++;
            $display("FAIL mid_async got=%b exp=0010", {o_valid, o_full, o_ready, o_ovf});
        end
        @(negedge clk);
        reset = 1'b1;
        d = rand_row();
        step('1, d, 1'b0);
        nvec++;
        if (o_valid !== 1'b1 || out_bus !== m_out() || mq[0].size() != 1) begin
            nerr++;
            $display("FAIL mid_newdata valid=%b got=%h exp=%h", o_valid, out_bus, m_out());
        end
        step('0, '0, 1'b1);
    endtask

    task automatic test_relu();
        logic [NC*W-1:0] d;
        logic [W-1:0]    exp0;
`ifdef OFIFO_RELU_EN
        exp0 = '0;
`else
        exp0 = 22'h3FFFFB;
`endif
        d = rand_row();
        d[0 +: W] = 22'h3FFFFB;
        d[W +: W] = 22'd7;
        step('1, d, 1'b0);
        nvec++;
        if (out_bus[0 +: W] !== exp0) begin
            nerr++;
            $display("FAIL relu_neg got=%h exp=%h", out_bus[0 +: W], exp0);
        end
        nvec++;
        if (out_bus[W +: W] !== 22'd7) begin
            nerr++;
            $display("FAIL relu_pos got=%h exp=7", out_bus[W +: W]);
        end
        step('0, '0, 1'b1);
        nvec++;
        if (o_valid !== 1'b0) begin
            nerr++;
            $display("FAIL relu_pop got=%b exp=0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_skewed_fill();
        test_full_ovf();
        test_wrap_simul();
        test_random();
        test_reset_mid();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
